// File: rtl/spi_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_frame_arbiter_if
// Bundles the two frame-source request ports, the status outputs and the
// display SPI pins of spi_frame_arbiter.
//   req0/req1     : level requests, held by each source until its ack
//   data0/data1   : FRAME_BITS-wide frames, sampled in the accept cycle only
//   ack0/ack1     : one-cycle accept pulses
//   src           : source of the current/last accepted frame
//   busy, done    : transaction in progress / one-cycle end-of-frame pulse
//   spi_sclk/mosi/cs_n : SPI mode-0 pins
// master = frame sources + pin consumer, slave = the arbiter itself.
// -----------------------------------------------------------------------------
interface spi_frame_arbiter_if #(
    parameter int FRAME_BITS = 40
);
    logic                  req0;
    logic                  req1;
    logic [FRAME_BITS-1:0] data0;
    logic [FRAME_BITS-1:0] data1;
    logic                  ack0;
    logic                  ack1;
    logic                  src;
    logic                  busy;
    logic                  done;
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_cs_n;

    modport master (
        output req0, req1, data0, data1,
        input  ack0, ack1, src, busy, done, spi_sclk, spi_mosi, spi_cs_n
    );

    modport slave (
        input  req0, req1, data0, data1,
        output ack0, ack1, src, busy, done, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_frame_arbiter.sv
// -----------------------------------------------------------------------------
// spi_frame_arbiter
// Round-robin arbiter between two frame sources feeding one display SPI link.
// The winner's frame is latched and sent as a single SPI mode-0 transaction,
// MSB first, with a sequenced (gated) SCLK and chip-select framing.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset (aborts any frame in flight)
//   bus : spi_frame_arbiter_if.slave (requests, frames, acks, status, pins)
// All outputs are registered.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cs_n high, waiting for req0/req1; accepts and latches a frame
// SETUP | cs_n low, sclk low for CLK_DIV cycles before the first rise
// SHIFT | sclk toggles every CLK_DIV cycles; mosi advances on each fall
// HOLD  | sclk low: last low half-period plus CLK_DIV hold, then cs_n rises
// GAP   | cs_n high for CS_GAP*CLK_DIV cycles before the next accept
// -----------------------------------------------------------------------------
module spi_frame_arbiter #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 40,
    parameter int CS_GAP     = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_frame_arbiter_if.slave  bus
);

    localparam int HOLD_CYC = 2 * CLK_DIV;
    localparam int GAP_CYC  = CS_GAP * CLK_DIV;
    localparam int MAX_CYC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW       = $clog2(MAX_CYC);
    localparam int BW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CW-1:0] LOAD_HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LOAD_HOLD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LOAD_GAP  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  src_q, src_d;
    logic                  last_grant_q, last_grant_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  grant1;
    logic                  cnt_zero;
    logic [FRAME_BITS-1:0] frame_in;
    logic [FRAME_BITS-1:0] sh_next;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        cs_n_d       = cs_n_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done_d       = 1'b0;

        // On a tie the port that did not win last time is served.
        grant1   = bus.req1 & (~bus.req0 | ~last_grant_q);
        frame_in = grant1 ? bus.data1 : bus.data0;
        cnt_zero = (cnt_q == '0);
        sh_next  = shreg_q << 1;

        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    src_d        = grant1;
                    last_grant_d = grant1;
                    ack0_d       = ~grant1;
                    ack1_d       = grant1;
                    shreg_d      = frame_in;
                    mosi_d       = frame_in[FRAME_BITS-1];
                    cs_n_d       = 1'b0;
                    cnt_d        = LOAD_HALF;
                    bit_d        = '0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    sclk_d  = 1'b1;
                    cnt_d   = LOAD_HALF;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_zero) begin
                    cnt_d = LOAD_HALF;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            mosi_d  = 1'b0;
                            cnt_d   = LOAD_HOLD;
                            state_d = HOLD;
                        end else begin
                            shreg_d = sh_next;
                            mosi_d  = sh_next[FRAME_BITS-1];
                            bit_d   = bit_q + BW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    cs_n_d = 1'b1;
                    done_d = 1'b1;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = LOAD_GAP;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.src      = src_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;

endmodule
